// File: rtl/cpu_multiciclo_param.sv
// Parametrised multi-cycle CPU: FETCH (req/ack handshake to program memory) -> EXEC, with HALT,
// conditional jumps, a saturating retired-instruction counter and a debug write-back port.
module cpu_multiciclo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NREG     = 16,
    parameter int unsigned PC_W     = 10,
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic                halted,
    output logic                z,
    output logic [PC_W-1:0]     dbg_pc,
    output logic                dbg_we,
    output logic [3:0]          dbg_wa,
    output logic [WIDTH-1:0]    dbg_wd,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [1:0] {StFetch, StExec, StHalt} state_t;

    state_t               state_q;
    logic [PC_W-1:0]      pc_q;
    logic [15:0]          ir_q;
    logic [WIDTH-1:0]     regs_q [NREG];
    logic                 z_q;
    logic [RETIRE_W-1:0]  retired_q;
    logic                 imem_req_q;
    logic                 halted_q;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     wr_data;
    logic                 is_alu;
    logic                 is_li;
    logic                 is_jmp;
    logic                 is_halt;
    logic                 jmp_taken;
    logic [PC_W-1:0]      pc_next;

    // Decode and datapath operate on the latched IR; register reads are combinational.
    always_comb begin
        op_a    = regs_q[ir_q[11:8]];
        op_b    = regs_q[ir_q[7:4]];
        is_alu  = ir_q[15];
        is_li   = (ir_q[15:12] == 4'h0);
        is_jmp  = (ir_q[15:12] == 4'h1);
        is_halt = (ir_q[15:12] == 4'h2);
        unique case (ir_q[14:12])
            3'b000:  alu_res = op_a;
            3'b001:  alu_res = ~op_a;
            3'b010:  alu_res = op_a + op_b;
            3'b011:  alu_res = op_a - op_b;
            3'b100:  alu_res = op_a & op_b;
            3'b101:  alu_res = op_a | op_b;
            3'b110:  alu_res = -op_a;
            default: alu_res = -op_b;
        endcase
        wr_data = is_alu ? alu_res : WIDTH'(ir_q[11:4]);
        jmp_taken = 1'b0;
        if (is_jmp) begin
            unique case (ir_q[11:10])
                2'b00:   jmp_taken = 1'b1;
                2'b01:   jmp_taken = z_q;
                2'b10:   jmp_taken = ~z_q;
                default: jmp_taken = 1'b0;
            endcase
        end
        pc_next = jmp_taken ? PC_W'(ir_q[9:0]) : pc_q + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            ir_q       <= '0;
            z_q        <= 1'b0;
            retired_q  <= '0;
            imem_req_q <= 1'b1;
            halted_q   <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    if (retired_q != '1) begin
                        retired_q <= retired_q + RETIRE_W'(1);
                    end
                    if (is_alu || is_li) begin
                        regs_q[ir_q[3:0]] <= wr_data;
                    end
                    if (is_alu) begin
                        z_q <= (alu_res == '0);
                    end
                    if (is_halt) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        pc_q       <= pc_next;
                        imem_req_q <= 1'b1;
                        state_q    <= StFetch;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign halted    = halted_q;
    assign z         = z_q;
    assign dbg_pc    = pc_q;
    assign dbg_we    = (state_q == StExec) && (is_alu || is_li);
    assign dbg_wa    = ir_q[3:0];
    assign dbg_wd    = wr_data;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_multiciclo_param.sv
// Bench for cpu_multiciclo_param: instruction-level reference model with a bench-driven memory
// responder, directed programs with literal expectations and a randomized program/wait run.
module tb_cpu_multiciclo_param;

    localparam int W  = 8;
    localparam int PW = 10;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [15:0]   imem_rdata = 16'h0;
    logic          halted;
    logic          z;
    logic [PW-1:0] dbg_pc;
    logic          dbg_we;
    logic [3:0]    dbg_wa;
    logic [W-1:0]  dbg_wd;
    logic [RW-1:0] retired;

    cpu_multiciclo_param #(.WIDTH(W), .NREG(16), .PC_W(PW), .RETIRE_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .halted     (halted),
        .z          (z),
        .dbg_pc     (dbg_pc),
        .dbg_we     (dbg_we),
        .dbg_wa     (dbg_wa),
        .dbg_wd     (dbg_wd),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    logic [15:0]   mem [1024];
    int            n_checks = 0;
    int            n_fail = 0;

    // Architectural model: one step per instruction, plus "waiting for exec" / halted flags.
    logic [W-1:0]  m_regs [16];
    logic          m_z;
    logic [PW-1:0] m_pc;
    logic [RW-1:0] m_ret;
    logic [15:0]   m_ir;
    bit            m_halt;
    bit            m_exec;
    int            wait_left = -1;
    int            max_wait = 0;
    bit            rand_wait = 1'b0;
    bit            checking = 1'b0;
    int            req_cycles = 0;
    logic [W-1:0]  last_wd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_result(input logic [15:0] ir);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = m_regs[ir[11:8]];
        b = m_regs[ir[7:4]];
        if (!ir[15]) return ir[11:4];
        case (ir[14:12])
            3'd0:    return a;
            3'd1:    return ~a;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return -a;
            default: return -b;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_z = 1'b0; m_pc = '0; m_ret = '0; m_ir = '0;
        m_halt = 1'b0; m_exec = 1'b0; wait_left = -1;
    endtask

    task automatic model_exec();
        logic [W-1:0] r;
        logic [1:0]   c;
        bit           taken;
        if (m_ret != '1) m_ret = m_ret + RW'(1);
        if (m_ir[15] || m_ir[15:12] == 4'h0) begin
            r = model_result(m_ir);
            m_regs[m_ir[3:0]] = r;
            if (m_ir[15]) m_z = (r == '0);
            m_pc = m_pc + PW'(1);
        end else if (m_ir[15:12] == 4'h1) begin
            c = m_ir[11:10];
            taken = (c == 2'd0) || (c == 2'd1 && m_z) || (c == 2'd2 && !m_z);
            m_pc = taken ? m_ir[9:0] : m_pc + PW'(1);
        end else if (m_ir[15:12] == 4'h2) begin
            m_halt = 1'b1;
        end else begin
            m_pc = m_pc + PW'(1);
        end
    endtask

    // One clock: compare DUT against the model, then drive this cycle's inputs and advance the model.
    task automatic cycle(input bit rst, input bit ack_in_rst);
        bit exp_we;
        @(negedge clk);
        if (checking) begin
            exp_we = m_exec && (m_ir[15] || m_ir[15:12] == 4'h0);
            chk("imem_req", 32'(imem_req), 32'(!m_halt && !m_exec));
            if (!m_halt && !m_exec) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("z", 32'(z), 32'(m_z));
            chk("dbg_pc", 32'(dbg_pc), 32'(m_pc));
            chk("retired", 32'(retired), 32'(m_ret));
            chk("dbg_we", 32'(dbg_we), 32'(exp_we));
            if (exp_we) begin
                chk("dbg_wa", 32'(dbg_wa), 32'(m_ir[3:0]));
                chk("dbg_wd", 32'(dbg_wd), 32'(model_result(m_ir)));
            end
            if (imem_req) req_cycles++;
            if (dbg_we) last_wd = dbg_wd;
        end
        reset = rst;
        imem_ack = 1'b0;
        imem_rdata = 16'($urandom);
        if (rst) begin
            imem_ack = ack_in_rst;
            model_reset();
            checking = 1'b1;
        end else if (m_exec) begin
            model_exec();
            m_exec = 1'b0;
        end else if (!m_halt) begin
            if (wait_left < 0) wait_left = rand_wait ? $urandom_range(max_wait, 0) : max_wait;
            if (wait_left == 0) begin
                imem_ack = 1'b1;
                imem_rdata = mem[m_pc];
                m_ir = mem[m_pc];
                m_exec = 1'b1;
                wait_left = -1;
            end else begin
                wait_left--;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'($urandom_range(1, 0)));
        req_cycles = 0;
        last_wd = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    // Runs until the model halts, then one more cycle so the halted state is compared.
    task automatic run_until_halt(input int limit, output int ncyc);
        ncyc = 0;
        while (!m_halt && ncyc < limit) begin
            cycle(1'b0, 1'b0);
            ncyc++;
        end
        if (!m_halt) chk("halt_timeout", 32'(0), 32'(1));
        cycle(1'b0, 1'b0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h3000;
    endtask

    function automatic logic [15:0] rand_instr();
        int k;
        k = $urandom_range(99, 0);
        if (k < 45)      return {1'b1, 15'($urandom)};
        else if (k < 70) return {4'h0, 12'($urandom)};
        else if (k < 88) return {4'h1, 12'($urandom)};
        else if (k < 98) return {4'($urandom_range(7, 3)), 12'($urandom)};
        else             return {4'h2, 12'($urandom)};
    endfunction

    initial begin
        int nc;

        // LI r1,5; LI r2,3; ADD r3,r1,r2; HALT -- zero-wait memory
        clear_mem();
        mem[0] = 16'h0051; mem[1] = 16'h0032; mem[2] = 16'hA123; mem[3] = 16'h2000;
        max_wait = 0; rand_wait = 1'b0;
        do_reset();
        run_until_halt(100, nc);
        chk("t1_cycles", 32'(nc), 32'd8);
        chk("t1_retired", 32'(retired), 32'd4);
        chk("t1_add_wd", 32'(last_wd), 32'd8);
        chk("t1_halt_pc", 32'(dbg_pc), 32'd3);

        // LI r1,7; SUB r2,r1,r1; JZ 0x020 -> taken
        clear_mem();
        mem[0] = 16'h0071; mem[1] = 16'hB112; mem[2] = 16'h1420; mem[16'h20] = 16'h2000;
        do_reset();
        run_until_halt(100, nc);
        chk("t2_jz_z", 32'(z), 32'd1);
        chk("t2_jz_pc", 32'(dbg_pc), 32'h20);

        // Same with JNZ -> not taken
        mem[2] = 16'h1820; mem[3] = 16'h2000;
        do_reset();
        run_until_halt(100, nc);
        chk("t2_jnz_pc", 32'(dbg_pc), 32'd3);

        // Modulo-2^8 wrap: 250 + 10 = 4
        clear_mem();
        mem[0] = 16'h0FA1; mem[1] = 16'h00A2; mem[2] = 16'hA123; mem[3] = 16'h2000;
        do_reset();
        run_until_halt(100, nc);
        chk("t3_wrap_wd", 32'(last_wd), 32'd4);
        chk("t3_wrap_z", 32'(z), 32'd0);

        // Three wait states per fetch
        clear_mem();
        mem[0] = 16'h0051; mem[1] = 16'h0032; mem[2] = 16'hA123; mem[3] = 16'h2000;
        max_wait = 3;
        do_reset();
        run_until_halt(200, nc);
        chk("t4_cycles", 32'(nc), 32'd20);
        chk("t4_req_cycles", 32'(req_cycles), 32'd16);
        chk("t4_retired", 32'(retired), 32'd4);
        chk("t4_add_wd", 32'(last_wd), 32'd8);

        // J 0x3FF then NOP: pc wraps to 0
        clear_mem();
        mem[0] = 16'h13FF; mem[1023] = 16'h3000;
        max_wait = 0;
        do_reset();
        run(3);
        chk("t5_addr_3ff", 32'(imem_addr), 32'h3FF);
        run(2);
        chk("t5_addr_wrap", 32'(imem_addr), 32'h000);
        chk("t5_retired", 32'(retired), 32'd2);

        // HALT at address 4, retired frozen afterwards
        clear_mem();
        mem[4] = 16'h2000;
        do_reset();
        run_until_halt(100, nc);
        chk("t6_halt_pc", 32'(dbg_pc), 32'd4);
        chk("t6_retired", 32'(retired), 32'd5);
        run(5);
        chk("t6_frozen", 32'(retired), 32'd5);
        chk("t6_req_low", 32'(imem_req), 32'd0);

        // Reset mid-fetch with a pending ack after r1/r2 were written; regs must read back 0
        clear_mem();
        mem[0] = 16'h0051; mem[1] = 16'h0032; mem[2] = 16'hA123; mem[3] = 16'h2000;
        max_wait = 3;
        do_reset();
        run(12);
        clear_mem();
        mem[0] = 16'hA123; mem[1] = 16'h2000;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t6_rst_retired", 32'(retired), 32'd0);
        chk("t6_rst_addr", 32'(imem_addr), 32'd0);
        chk("t6_rst_req", 32'(imem_req), 32'd1);
        last_wd = 8'hFF;
        run_until_halt(100, nc);
        chk("t6_rst_regs", 32'(last_wd), 32'd0);
        chk("t6_rst_z", 32'(z), 32'd1);

        // Random programs with random wait states and random resets
        rand_wait = 1'b1;
        max_wait = 3;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 1024; i++) mem[i] = rand_instr();
            do_reset();
            for (int i = 0; i < 800; i++) begin
                if ((m_halt && $urandom_range(9, 0) == 0) || $urandom_range(299, 0) == 0) begin
                    cycle(1'b1, 1'($urandom_range(1, 0)));
                end else begin
                    cycle(1'b0, 1'b0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
